game_state_ctrl: RTL

Parametrised successor to the single-round game state machine. Adds multi-level progression, a lives counter, timed inter-round delays, edge-detected keyboard commands and configurable key codes. Sits between the USB keyboard keycode path and the game datapath (alien array, player, HUD). Drives round-reset and level-start pulses so the datapath re-initialises without a global reset.

---
 rtl/game_state_ctrl.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/game_state_ctrl.sv
// Game-flow controller: sits between the keyboard keycode path and the game
// datapath. It tracks level and lives, inserts timed pauses between rounds,
// and emits one-cycle game_reset / level_start pulses so the datapath
// re-initialises itself without needing a global reset.
module game_state_ctrl #(
    parameter int unsigned NUM_LEVELS   = 3,
    parameter int unsigned NUM_LIVES    = 3,
    parameter int unsigned DELAY_CYCLES = 50000000,
    parameter logic [7:0]  START_KEY    = 8'h2B,
    parameter logic [7:0]  PAUSE_KEY    = 8'h14,
    localparam int unsigned LW = ($clog2(NUM_LEVELS) > 0) ? $clog2(NUM_LEVELS) : 1,
    localparam int unsigned VW = $clog2(NUM_LIVES + 1)
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic [7:0]    keycode,
    input  logic          lose,
    input  logic          win,
    output logic [2:0]    curr_state,
    output logic [LW-1:0] level,
    output logic [VW-1:0] lives,
    output logic          game_reset,
    output logic          level_start,
    output logic          running
);

    localparam int unsigned TW = ($clog2(DELAY_CYCLES) > 0) ? $clog2(DELAY_CYCLES) : 1;

    localparam logic [LW-1:0] LastLevel = LW'(NUM_LEVELS - 1);
    localparam logic [VW-1:0] MaxLives  = VW'(NUM_LIVES);
    localparam logic [TW-1:0] TimerLast = TW'(DELAY_CYCLES - 1);

    typedef enum logic [2:0] {
        StStart      = 3'd0,
        StPlay       = 3'd1,
        StPause      = 3'd2,
        StLifeLost   = 3'd3,
        StGameOver   = 3'd4,
        StLevelClear = 3'd5,
        StWin        = 3'd6
    } state_e;

    state_e        state_q, state_d;
    logic [LW-1:0] level_q, level_d;
    logic [VW-1:0] lives_q, lives_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [7:0]    key_prev_q;
    logic          game_reset_q, game_reset_d;
    logic          level_start_q, level_start_d;
    logic          running_q, running_d;

    logic          start_ev;
    logic          pause_ev;
    logic          timer_done;
    logic [TW-1:0] timer_inc;

    // Rising-edge key events: a held key fires only on the cycle it first appears.
    always_comb begin
        start_ev = (keycode == START_KEY) && (key_prev_q != START_KEY);
        pause_ev = (keycode == PAUSE_KEY) && (key_prev_q != PAUSE_KEY);
    end

    // Delay timer helpers: saturating increment, and ">=" so a corrupted
    // timer value still leaves the delay state instead of stalling.
    always_comb begin
        timer_inc  = (&timer_q) ? timer_q : timer_q + 1'b1;
        timer_done = (timer_q >= TimerLast);
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d       = state_q;
        level_d       = level_q;
        lives_d       = lives_q;
        timer_d       = timer_q;
        game_reset_d  = 1'b0;
        level_start_d = 1'b0;

        case (state_q)
            StStart: begin
                if (start_ev) begin
                    state_d       = StPlay;
                    level_d       = '0;
                    lives_d       = MaxLives;
                    game_reset_d  = 1'b1;
                    level_start_d = 1'b1;
                end
            end

            StPlay: begin
                // Priority: lose > win > pause.
                if (lose) begin
                    // "<= 1" also guards against underflow if lives is ever 0 here.
                    if (lives_q <= VW'(1)) begin
                        state_d = StGameOver;
                        lives_d = '0;
                    end else begin
                        state_d = StLifeLost;
                        lives_d = lives_q - 1'b1;
                        timer_d = '0;
                    end
                end else if (win) begin
                    if (level_q >= LastLevel) begin
                        state_d = StWin;
                    end else begin
                        state_d = StLevelClear;
                        timer_d = '0;
                    end
                end else if (pause_ev) begin
                    state_d = StPause;
                end
            end

            StPause: begin
                if (pause_ev) begin
                    state_d = StPlay;
                end
            end

            StLifeLost: begin
                timer_d = timer_inc;
                if (timer_done) begin
                    state_d       = StPlay;
                    level_start_d = 1'b1;
                end
            end

            StLevelClear: begin
                timer_d = timer_inc;
                if (timer_done) begin
                    state_d       = StPlay;
                    level_start_d = 1'b1;
                    if (level_q < LastLevel) begin
                        level_d = level_q + 1'b1;
                    end
                end
            end

            StGameOver, StWin: begin
                if (start_ev) begin
                    state_d = StStart;
                end
            end

            // Unused encoding 7 falls back to START.
            default: begin
                state_d = StStart;
            end
        endcase

        running_d = (state_d == StPlay);
    end

    // State and registered outputs; synchronous active-low reset dominates.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q       <= StStart;
            level_q       <= '0;
            lives_q       <= MaxLives;
            timer_q       <= '0;
            key_prev_q    <= 8'h00;
            game_reset_q  <= 1'b0;
            level_start_q <= 1'b0;
            running_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            level_q       <= level_d;
            lives_q       <= lives_d;
            timer_q       <= timer_d;
            key_prev_q    <= keycode;
            game_reset_q  <= game_reset_d;
            level_start_q <= level_start_d;
            running_q     <= running_d;
        end
    end

    // Output mapping.
    always_comb begin
        curr_state  = state_q;
        level       = level_q;
        lives       = lives_q;
        game_reset  = game_reset_q;
        level_start = level_start_q;
        running     = running_q;
    end

endmodule
